debounce_ce_gen: RTL

- Upstream conditioning stage for the D flip-flop with clock enable and synchronous reset.
- Takes a raw, asynchronous, bouncy input (switch or button) and synchronises it to Clk.
- Debounces it with a consecutive-cycle counter and drives the flop's D input with the accepted level.
- Drives the flop's ce input with a single-cycle pulse each time the accepted level changes.

---
 rtl/debounce_ce_gen.sv | 124 ++++++++++++
 1 files changed

// File: rtl/debounce_ce_gen.sv
// Synchronises and debounces a raw switch level, then drives a downstream flop's D and ce.
// Define DEBOUNCE_RISE_ONLY_EN to pulse ce only on accepted 0->1 changes.
module debounce_ce_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic reset,
    input  logic raw_in,
    input  logic enable,
    output logic D,
    output logic ce,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [0:0] ST_STABLE = 1'b0;
    localparam logic [0:0] ST_COUNT  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_q, d_d;
    logic             ce_q, ce_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             accept;

    // The synchroniser runs every cycle regardless of enable so it never holds a stale sample.
    // NOTE: sequential state always uses <= so every flop samples pre-edge values together.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // NOTE: every output of this block is defaulted first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        accept  = 1'b0;

        if (enable) begin
            case (state_q)
                ST_STABLE: begin
                    if (sync_out != d_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            state_d = ST_COUNT;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                ST_COUNT: begin
                    if (sync_out == d_q) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        accept = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        if (accept) begin
            d_d     = sync_out;
            state_d = ST_STABLE;
            cnt_d   = '0;
        end

        rise_d = accept & sync_out;
        fall_d = accept & ~sync_out;
`ifdef DEBOUNCE_RISE_ONLY_EN
        ce_d = rise_d;
`else
        ce_d = accept;
`endif
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            ce_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            ce_q    <= ce_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign D    = d_q;
    assign ce   = ce_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_COUNT);

endmodule
